// File: rtl/sevenseg_arbiter.sv
// Three-requester round-robin arbiter for a shared seven-segment display.
// Requester 0 may preempt the others; every grant holds the display for a minimum dwell.
module sevenseg_arbiter #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [47:0] req_data,
  output logic [2:0]  req_ack,
  output logic [15:0] seg_data,
  output logic [1:0]  seg_owner,
  output logic        disp_active
);

  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [1:0]       OWNER_NONE = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rr_last_q, rr_last_d;
  logic [15:0]      seg_data_d;
  logic [1:0]       seg_owner_d;
  logic [2:0]       req_ack_d;
  logic             disp_active_d;

  logic [1:0]       cand0, cand1, cand2;
  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic             grant;
  logic [1:0]       grant_idx;
  logic [15:0]      grant_data;

  function automatic logic [1:0] rr_inc(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Round-robin search: the last winner ranks lowest.
  always_comb begin
    cand0      = rr_inc(rr_last_q);
    cand1      = rr_inc(cand0);
    cand2      = rr_last_q;
    pick_valid = 1'b1;
    pick_idx   = cand0;
    if (req_valid[cand0]) begin
      pick_idx = cand0;
    end else if (req_valid[cand1]) begin
      pick_idx = cand1;
    end else if (req_valid[cand2]) begin
      pick_idx = cand2;
    end else begin
      pick_valid = 1'b0;
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    grant_data = req_data[15:0];
      2'd1:    grant_data = req_data[31:16];
      default: grant_data = req_data[47:32];
    endcase
  end

  // Next-state and next-output logic; preemption by requester 0 beats expiry.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_last_d     = rr_last_q;
    seg_data_d    = seg_data;
    seg_owner_d   = seg_owner;
    req_ack_d     = 3'b000;
    disp_active_d = disp_active;
    grant         = 1'b0;
    grant_idx     = 2'd0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant     = 1'b1;
          grant_idx = pick_idx;
        end
      end
      SHOW: begin
        if ((seg_owner != 2'd0) && req_valid[0]) begin
          grant     = 1'b1;
          grant_idx = 2'd0;
        end else if (cnt_q == CNT_ZERO) begin
          if (pick_valid) begin
            grant     = 1'b1;
            grant_idx = pick_idx;
          end else begin
            state_d       = IDLE;
            seg_data_d    = IDLE_PATTERN;
            seg_owner_d   = OWNER_NONE;
            disp_active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant) begin
      state_d       = SHOW;
      cnt_d         = CNT_LOAD;
      rr_last_d     = grant_idx;
      seg_data_d    = grant_data;
      seg_owner_d   = grant_idx;
      req_ack_d     = 3'b001 << grant_idx;
      disp_active_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      rr_last_q   <= 2'd2;
      seg_data    <= IDLE_PATTERN;
      seg_owner   <= OWNER_NONE;
      req_ack     <= 3'b000;
      disp_active <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_last_q   <= rr_last_d;
      seg_data    <= seg_data_d;
      seg_owner   <= seg_owner_d;
      req_ack     <= req_ack_d;
      disp_active <= disp_active_d;
    end
  end

endmodule
